// File: rtl/fourth_step.sv
// Memory-access stage of a 5-stage pipeline: EX/MEM register, word-addressed
// data memory with alignment checking, and MEM/WB register.
module fourth_step #(
    parameter int unsigned DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        branch,
    input  logic        regWrite,
    input  logic        memToReg,
    input  logic [31:0] addResult,
    input  logic        zero,
    input  logic [31:0] aluResult,
    input  logic [31:0] reg2Out,
    input  logic [4:0]  muxRegDstOut,
    output logic        pcSrc,
    output logic [31:0] branchTarget,
    output logic [31:0] readData,
    output logic [31:0] aluResultOut,
    output logic [4:0]  writeReg,
    output logic        regWriteOut,
    output logic        memToRegOut,
    output logic        misaligned
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef struct packed {
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        reg_write;
        logic        mem_to_reg;
        logic        zero;
        logic [31:0] add_result;
        logic [31:0] alu_result;
        logic [31:0] reg2;
        logic [4:0]  dst;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] read_data;
        logic [31:0] alu_result;
        logic [4:0]  dst;
        logic        reg_write;
        logic        mem_to_reg;
        logic        misaligned;
    } mem_wb_t;

    ex_mem_t ex_mem_d, ex_mem_q;
    mem_wb_t mem_wb_d, mem_wb_q;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] mem_idx;
    logic          mem_fault;
    logic          mem_wr_en;
    logic [31:0]   mem_rd_val;

    always_comb begin
        ex_mem_d            = '0;
        ex_mem_d.zero       = zero;
        ex_mem_d.add_result = addResult;
        ex_mem_d.alu_result = aluResult;
        ex_mem_d.reg2       = reg2Out;
        ex_mem_d.dst        = muxRegDstOut;
        // A flushed instruction keeps its data fields but loses all control.
        if (!flush) begin
            ex_mem_d.mem_read   = memRead;
            ex_mem_d.mem_write  = memWrite;
            ex_mem_d.branch     = branch;
            ex_mem_d.reg_write  = regWrite;
            ex_mem_d.mem_to_reg = memToReg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_mem_q <= '0;
        end else begin
            ex_mem_q <= ex_mem_d;
        end
    end

    always_comb begin
        mem_idx    = ex_mem_q.alu_result[AW+1:2];
        mem_fault  = (ex_mem_q.mem_read || ex_mem_q.mem_write)
                     && (ex_mem_q.alu_result[1:0] != 2'b00);
        mem_wr_en  = ex_mem_q.mem_write && !mem_fault;
        mem_rd_val = '0;
        // A store wins over a simultaneous load; the load then returns zero.
        if (ex_mem_q.mem_read && !ex_mem_q.mem_write && !mem_fault) begin
            mem_rd_val = mem[mem_idx];
        end
    end

    // No reset: memory contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_wr_en) begin
            mem[mem_idx] <= ex_mem_q.reg2;
        end
    end

    always_comb begin
        mem_wb_d            = '0;
        mem_wb_d.read_data  = mem_rd_val;
        mem_wb_d.alu_result = ex_mem_q.alu_result;
        mem_wb_d.dst        = ex_mem_q.dst;
        mem_wb_d.reg_write  = ex_mem_q.reg_write && !mem_fault;
        mem_wb_d.mem_to_reg = ex_mem_q.mem_to_reg;
        mem_wb_d.misaligned = mem_fault;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_wb_q <= '0;
        end else begin
            mem_wb_q <= mem_wb_d;
        end
    end

    assign pcSrc        = ex_mem_q.branch && ex_mem_q.zero;
    assign branchTarget = ex_mem_q.add_result;
    assign readData     = mem_wb_q.read_data;
    assign aluResultOut = mem_wb_q.alu_result;
    assign writeReg     = mem_wb_q.dst;
    assign regWriteOut  = mem_wb_q.reg_write;
    assign memToRegOut  = mem_wb_q.mem_to_reg;
    assign misaligned   = mem_wb_q.misaligned;

endmodule
